// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
//   CPU-side request/complete bundle between the control unit / MAR / MDR and
//   the memory access sequencer.
//
//   mov    memory operation valid (request strobe), 4-phase with moc
//   r_w    1 = read, 0 = write
//   dt     00 byte, 01 halfword, 10 word, 11 reserved
//   sign   sign-extend read data (byte/halfword only)
//   addr   byte address from MAR
//   wdata  store data from MDR (low bytes used for byte/halfword)
//   rdata  assembled, extended read data, valid while moc=1
//   moc    memory operation complete
//   abort  access rejected, valid while moc=1
//
//   modport master : control unit side (drives the request)
//   modport slave  : sequencer side (drives completion and read data)
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              mov;
  logic              r_w;
  logic [1:0]        dt;
  logic              sign;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              moc;
  logic              abort;

  modport master (
    output mov, r_w, dt, sign, addr, wdata,
    input  rdata, moc, abort
  );

  modport slave (
    input  mov, r_w, dt, sign, addr, wdata,
    output rdata, moc, abort
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   Sequencer between the CPU datapath and a byte-wide RAM. Each byte,
//   halfword or word request is split into byte-wide RAM cycles, MSB byte at
//   the lowest address (big-endian). Read bytes are assembled and zero- or
//   sign-extended to 32 bits; completion is signalled with a 4-phase
//   mov/moc handshake.
//
//   Optional build macro MEM_ALIGN_CHK_EN: when defined, misaligned halfword
//   and word requests abort in one cycle without touching the RAM. When
//   undefined, only dt=11 aborts and misaligned accesses run byte by byte
//   with address wrap.
//
// Parameters
//   RAM_LAT   read latency from ram_re to valid ram_rdata, 1..4 cycles
//   ADDR_W    byte address width
//
// Ports
//   clk        system clock, rising edge
//   clr        asynchronous active-low reset
//   cpu        CPU request bundle (slave side)
//   ram_addr   byte address to RAM
//   ram_re     RAM read strobe, one cycle per byte
//   ram_we     RAM write strobe, one cycle per byte
//   ram_wdata  byte to RAM
//   ram_rdata  byte from RAM
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int RAM_LAT = 1,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              clr,
  mem_access_ctrl_if.slave  cpu,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state;
  logic              rw_q;
  logic [1:0]        dt_q;
  logic              sign_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [31:0]       acc;
  logic [1:0]        idx;
  logic [1:0]        idx_nxt;
  logic [1:0]        wait_cnt;
  logic [31:0]       rdata_q;
  logic              moc_q;
  logic              abort_q;
  logic              req_illegal;

  assign cpu.rdata = rdata_q;
  assign cpu.moc   = moc_q;
  assign cpu.abort = abort_q;
  assign idx_nxt   = idx + 2'd1;

  // Index of the last byte of the operand: N-1.
  function automatic logic [1:0] last_idx(input logic [1:0] dt);
    case (dt)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Byte i of the operand counted MSB first, i.e. byte (N-1-i) of wdata.
  function automatic logic [7:0] wr_byte(input logic [31:0] wd,
                                         input logic [1:0]  dt,
                                         input logic [1:0]  i);
    logic [1:0] k;
    k = last_idx(dt) - i;
    return wd[{k, 3'b000} +: 8];
  endfunction

  // Right-justified N-byte value, extended to 32 bits.
  function automatic logic [31:0] extend(input logic [31:0] a,
                                         input logic [1:0]  dt,
                                         input logic        sg);
    case (dt)
      2'b00:   return {{24{sg & a[7]}},  a[7:0]};
      2'b01:   return {{16{sg & a[15]}}, a[15:0]};
      default: return a;
    endcase
  endfunction

  always_comb begin
    req_illegal = (cpu.dt == 2'b11);
`ifdef MEM_ALIGN_CHK_EN
    if (cpu.dt == 2'b01 && cpu.addr[0])         req_illegal = 1'b1;
    if (cpu.dt == 2'b10 && cpu.addr[1:0] != '0) req_illegal = 1'b1;
`endif
  end

  // NOTE: non-blocking assignments only, so every branch below sees the
  // pre-edge values of the state registers regardless of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= S_IDLE;
      rw_q      <= 1'b0;
      dt_q      <= 2'b00;
      sign_q    <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      acc       <= '0;
      idx       <= '0;
      wait_cnt  <= '0;
      rdata_q   <= '0;
      moc_q     <= 1'b0;
      abort_q   <= 1'b0;
      ram_addr  <= '0;
      ram_re    <= 1'b0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu.mov && !moc_q) begin
            rw_q     <= cpu.r_w;
            dt_q     <= cpu.dt;
            sign_q   <= cpu.sign;
            base_q   <= cpu.addr;
            wdata_q  <= cpu.wdata;
            acc      <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            if (req_illegal) begin
              state   <= S_DONE;
              moc_q   <= 1'b1;
              abort_q <= 1'b1;
              rdata_q <= '0;
            end else begin
              // Strobes are registered: they go high for exactly the ISSUE
              // cycle, using the request fields straight off the bus.
              state    <= S_ISSUE;
              ram_addr <= cpu.addr;
              ram_re   <= cpu.r_w;
              ram_we   <= !cpu.r_w;
              if (!cpu.r_w) ram_wdata <= wr_byte(cpu.wdata, cpu.dt, 2'd0);
            end
          end
        end

        S_ISSUE: begin
          ram_re <= 1'b0;
          ram_we <= 1'b0;
          if (rw_q) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end else begin
            state <= S_NEXT;
          end
        end

        S_WAIT: begin
          if (wait_cnt == 2'(RAM_LAT - 1)) begin
            acc   <= {acc[23:0], ram_rdata};
            state <= S_NEXT;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end

        S_NEXT: begin
          if (idx == last_idx(dt_q)) begin
            state <= S_DONE;
            moc_q <= 1'b1;
            if (rw_q) rdata_q <= extend(acc, dt_q, sign_q);
          end else begin
            idx      <= idx_nxt;
            state    <= S_ISSUE;
            ram_addr <= base_q + ADDR_W'(idx_nxt);  // wraps at 2**ADDR_W
            ram_re   <= rw_q;
            ram_we   <= !rw_q;
            if (!rw_q) ram_wdata <= wr_byte(wdata_q, dt_q, idx_nxt);
          end
        end

        S_DONE: begin
          // Leaving only on mov=0 is what prevents re-triggering while the
          // control unit still holds mov high.
          if (!cpu.mov) begin
            state   <= S_IDLE;
            moc_q   <= 1'b0;
            abort_q <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl with a behavioural 256x8 RAM whose
//   read data appears RAM_LAT cycles after ram_re. Honours MEM_ALIGN_CHK_EN
//   when choosing expected values for misaligned accesses.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;
  localparam int RAM_LAT = 1;
  localparam int ADDR_W  = 8;

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  int vectors     = 0;
  int miscompares = 0;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W)) cpu_if ();

  mem_access_ctrl #(.RAM_LAT(RAM_LAT), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .clr       (clr),
    .cpu       (cpu_if.slave),
    .ram_addr  (ram_addr),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM and strobe monitors
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] rd_pipe [RAM_LAT];
  int         re_cnt       = 0;
  int         we_cnt       = 0;
  int         both_hi      = 0;
  logic [7:0] last_re_addr = 8'h00;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rd_pipe[0] <= ram_re ? mem[ram_addr] : 8'h00;
    for (int j = 1; j < RAM_LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
    if (ram_re) begin
      re_cnt       <= re_cnt + 1;
      last_re_addr <= ram_addr;
    end
    if (ram_we) we_cnt <= we_cnt + 1;
    if (ram_re && ram_we) both_hi <= both_hi + 1;
  end
  assign ram_rdata = rd_pipe[RAM_LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the bus after the sampling edge, and wait for
  // moc. lat counts edges from the sampling edge (=1) to the edge raising moc.
  task automatic do_access(input logic rw, input logic [1:0] dt, input logic sg,
                           input logic [7:0] a, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic ab);
    @(negedge clk);
    cpu_if.mov   = 1'b1;
    cpu_if.r_w   = rw;
    cpu_if.dt    = dt;
    cpu_if.sign  = sg;
    cpu_if.addr  = a;
    cpu_if.wdata = wd;
    @(posedge clk);
    lat = 1;
    #1;
    cpu_if.r_w   = ~rw;
    cpu_if.dt    = ~dt;
    cpu_if.sign  = ~sg;
    cpu_if.addr  = ~a;
    cpu_if.wdata = ~wd;
    while (cpu_if.moc !== 1'b1 && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
    rd = cpu_if.rdata;
    ab = cpu_if.abort;
  endtask

  task automatic release_access(input string tag);
    @(negedge clk);
    cpu_if.mov = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " moc low"}, 32'(cpu_if.moc), 32'd0);
    check({tag, " abort low"}, 32'(cpu_if.abort), 32'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        ab;
    int          re0;
    int          we0;

    cpu_if.mov   = 1'b0;
    cpu_if.r_w   = 1'b0;
    cpu_if.dt    = 2'b00;
    cpu_if.sign  = 1'b0;
    cpu_if.addr  = '0;
    cpu_if.wdata = '0;

    // Reset state
    #12;
    check("rst moc", 32'(cpu_if.moc), 32'd0);
    check("rst abort", 32'(cpu_if.abort), 32'd0);
    check("rst rdata", cpu_if.rdata, 32'd0);
    check("rst strobes", {30'd0, ram_re, ram_we}, 32'd0);
    @(negedge clk);
    clr = 1'b1;

    // Word write A1B2C3D4 at 0x10
    we0 = we_cnt;
    do_access(1'b0, 2'b10, 1'b0, 8'h10, 32'hA1B2C3D4, lat, rd, ab);
    check("wr32 latency", 32'(lat), 32'd9);
    check("wr32 abort", 32'(ab), 32'd0);
    check("wr32 rdata unchanged", rd, 32'd0);
    check("wr32 ram", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hA1B2C3D4);
    check("wr32 we count", 32'(we_cnt - we0), 32'd4);
    release_access("wr32");

    // Halfword reads at 0x12, signed and unsigned
    do_access(1'b1, 2'b01, 1'b1, 8'h12, 32'h0, lat, rd, ab);
    check("rd16s rdata", rd, 32'hFFFFC3D4);
    check("rd16s latency", 32'(lat), 32'(2 * (RAM_LAT + 2) + 1));
    release_access("rd16s");
    do_access(1'b1, 2'b01, 1'b0, 8'h12, 32'h0, lat, rd, ab);
    check("rd16u rdata", rd, 32'h0000C3D4);
    release_access("rd16u");

    // clr asserted in the middle of a read
    @(negedge clk);
    cpu_if.mov  = 1'b1;
    cpu_if.r_w  = 1'b1;
    cpu_if.dt   = 2'b10;
    cpu_if.addr = 8'h10;
    @(posedge clk);
    #1;
    check("midrst re before", 32'(ram_re), 32'd1);
    #1;
    clr = 1'b0;
    #1;
    check("midrst rdata", cpu_if.rdata, 32'd0);
    check("midrst ram", {15'd0, ram_re, ram_we, ram_addr, ram_wdata}, 32'd0);
    check("midrst moc", 32'(cpu_if.moc), 32'd0);
    @(negedge clk);
    cpu_if.mov = 1'b0;
    clr        = 1'b1;

    // Byte read at 0x11, signed
    do_access(1'b1, 2'b00, 1'b1, 8'h11, 32'h0, lat, rd, ab);
    check("rd8s rdata", rd, 32'hFFFFFFB2);
    check("rd8s latency", 32'(lat), 32'(RAM_LAT + 3));
    release_access("rd8s");

    // Misaligned word read at 0x11
    re0 = re_cnt;
    do_access(1'b1, 2'b10, 1'b0, 8'h11, 32'h0, lat, rd, ab);
`ifdef MEM_ALIGN_CHK_EN
    check("mis32 abort", 32'(ab), 32'd1);
    check("mis32 latency", 32'(lat), 32'd1);
    check("mis32 rdata", rd, 32'd0);
    check("mis32 no re", 32'(re_cnt - re0), 32'd0);
`else
    check("mis32 abort", 32'(ab), 32'd0);
    check("mis32 rdata", rd, 32'hB2C3D400);
    check("mis32 latency", 32'(lat), 32'(4 * (RAM_LAT + 2) + 1));
    check("mis32 re count", 32'(re_cnt - re0), 32'd4);
`endif
    release_access("mis32");

    // Byte writes across the top of memory, then a word read at 0xFE
    do_access(1'b0, 2'b00, 1'b0, 8'hFE, 32'hAAAAAA11, lat, rd, ab);
    check("wr8 latency", 32'(lat), 32'd3);
    release_access("wr8 fe");
    do_access(1'b0, 2'b00, 1'b0, 8'hFF, 32'hAAAAAA22, lat, rd, ab);
    release_access("wr8 ff");
    do_access(1'b0, 2'b00, 1'b0, 8'h00, 32'hAAAAAA33, lat, rd, ab);
    release_access("wr8 00");
    do_access(1'b0, 2'b00, 1'b0, 8'h01, 32'hAAAAAA44, lat, rd, ab);
    release_access("wr8 01");
    check("wr8 ram", {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]}, 32'h11223344);
    re0 = re_cnt;
    do_access(1'b1, 2'b10, 1'b1, 8'hFE, 32'h0, lat, rd, ab);
`ifdef MEM_ALIGN_CHK_EN
    check("wrap32 abort", 32'(ab), 32'd1);
    check("wrap32 no re", 32'(re_cnt - re0), 32'd0);
`else
    check("wrap32 rdata", rd, 32'h11223344);
    check("wrap32 last addr", 32'(last_re_addr), 32'h01);
`endif
    release_access("wrap32");

    // mov held high long after completion: exactly one access
    re0 = re_cnt;
    do_access(1'b1, 2'b00, 1'b0, 8'h10, 32'h0, lat, rd, ab);
    check("hold rdata", rd, 32'h000000A1);
    repeat (20) @(posedge clk);
    #1;
    check("hold moc", 32'(cpu_if.moc), 32'd1);
    check("hold re count", 32'(re_cnt - re0), 32'd1);
    release_access("hold");

    // Reserved dt always aborts with no strobes
    re0 = re_cnt;
    we0 = we_cnt;
    do_access(1'b0, 2'b11, 1'b0, 8'h30, 32'hDEADBEEF, lat, rd, ab);
    check("dt11 abort", 32'(ab), 32'd1);
    check("dt11 latency", 32'(lat), 32'd1);
    check("dt11 strobes", 32'((re_cnt - re0) + (we_cnt - we0)), 32'd0);
    release_access("dt11");

    // mov dropped during a word write
    we0 = we_cnt;
    @(negedge clk);
    cpu_if.mov   = 1'b1;
    cpu_if.r_w   = 1'b0;
    cpu_if.dt    = 2'b10;
    cpu_if.addr  = 8'h20;
    cpu_if.wdata = 32'h55667788;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    cpu_if.mov = 1'b0;
    #1;
    while (cpu_if.moc !== 1'b1 && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("drop latency", 32'(lat), 32'd9);
    @(posedge clk);
    #1;
    check("drop moc pulse", 32'(cpu_if.moc), 32'd0);
    check("drop ram", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'h55667788);
    check("drop we count", 32'(we_cnt - we0), 32'd4);

    check("re/we overlap", 32'(both_hi), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
